// File: rtl/wb_trace_checker.sv
// wb_trace_checker: buffers committed register writes and checks them in order against a golden trace stream
module wb_trace_checker #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] END_PC     = 32'h1c000100,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      wb_pc,
    input  logic [3:0]       wb_rf_we,
    input  logic [4:0]       wb_rf_wnum,
    input  logic [31:0]      wb_rf_wdata,
    input  logic             gold_valid,
    output logic             gold_ready,
    input  logic [31:0]      gold_pc,
    input  logic [4:0]       gold_wnum,
    input  logic [31:0]      gold_wdata,
    input  logic             gold_end,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             overflow,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [31:0]      err_pc,
    output logic [4:0]       err_wnum,
    output logic [31:0]      err_exp_wdata,
    output logic [31:0]      err_got_wdata
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} state_t;

    state_t        state;
    logic [68:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [68:0]   head;
    logic          active, empty, full, commit, pop, push, mism, ovf, extra, end_det;

    assign active     = (state == RUN) || (state == DRAIN);
    assign empty      = count == '0;
    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign head       = mem[rd_ptr];
    assign commit     = active && (|wb_rf_we) && (wb_rf_wnum != 5'd0);
    assign pop        = active && !empty && gold_valid;
    assign push       = commit && (!full || pop);
    assign mism       = pop && (head != {gold_pc, gold_wnum, gold_wdata});
    assign ovf        = commit && full && !pop;
    assign extra      = active && gold_end && !empty && !gold_valid;
    assign end_det    = (state == RUN) && (wb_pc == END_PC);
    assign gold_ready = pop;
    assign pass       = state == PASS;
    assign fail       = state == FAIL;
    assign done       = pass | fail;

    // commit storage, written at the tail; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {wb_pc, wb_rf_wnum, wb_rf_wdata};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // verdict FSM with match counter and first-failure capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            overflow      <= 1'b0;
            checked_cnt   <= '0;
            err_pc        <= '0;
            err_wnum      <= '0;
            err_exp_wdata <= '0;
            err_got_wdata <= '0;
        end else begin
            if (pop && !mism) checked_cnt <= checked_cnt + CNT_W'(1);
            if (mism) begin
                state         <= FAIL;
                err_pc        <= head[68:37];
                err_wnum      <= head[36:32];
                err_got_wdata <= head[31:0];
                err_exp_wdata <= gold_wdata;
            end else if (ovf) begin
                state    <= FAIL;
                overflow <= 1'b1;
            end else if (extra) begin
                state         <= FAIL;
                err_pc        <= head[68:37];
                err_wnum      <= head[36:32];
                err_got_wdata <= head[31:0];
                err_exp_wdata <= '0;
            end else if (end_det) begin
                state <= DRAIN;
            end else if (state == DRAIN && empty && !commit) begin
                state <= PASS;
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed and randomized checks of wb_trace_checker against a queue-based reference model
module tb_wb_trace_checker;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] END_PC  = 32'h1c000100;
    localparam logic [31:0] IDLE_PC = 32'h1c000ff0;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_pc = IDLE_PC;
    logic [3:0]  wb_rf_we = '0;
    logic [4:0]  wb_rf_wnum = '0;
    logic [31:0] wb_rf_wdata = '0;
    logic        gold_valid = 1'b0;
    logic        gold_ready;
    logic [31:0] gold_pc = '0;
    logic [4:0]  gold_wnum = '0;
    logic [31:0] gold_wdata = '0;
    logic        gold_end = 1'b0;
    logic        done, pass, fail, overflow;
    logic [31:0] checked_cnt, err_pc, err_exp_wdata, err_got_wdata;
    logic [4:0]  err_wnum;

    wb_trace_checker #(.FIFO_DEPTH(DEPTH), .END_PC(END_PC), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_wnum(wb_rf_wnum), .wb_rf_wdata(wb_rf_wdata),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc),
        .gold_wnum(gold_wnum), .gold_wdata(gold_wdata), .gold_end(gold_end),
        .done(done), .pass(pass), .fail(fail), .overflow(overflow), .checked_cnt(checked_cnt),
        .err_pc(err_pc), .err_wnum(err_wnum), .err_exp_wdata(err_exp_wdata), .err_got_wdata(err_got_wdata)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ready_pulses;
    wb_t         stim[$];
    logic [68:0] gq[$];
    bit          stall_q[$];
    int          stall_pct;
    bit          end_en;

    logic [68:0] mq[$];
    bit          m_pass, m_fail, m_drain, m_ovf, m_pop;
    logic [31:0] m_cnt, m_epc, m_eexp, m_egot;
    logic [4:0]  m_ewn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_pass = 0; m_fail = 0; m_drain = 0; m_ovf = 0; m_pop = 0;
        m_cnt = 0; m_epc = 0; m_eexp = 0; m_egot = 0; m_ewn = 0;
    endfunction

    function automatic void capture(input logic [68:0] h, input logic [31:0] exp);
        m_fail = 1;
        m_epc  = h[68:37];
        m_ewn  = h[36:32];
        m_egot = h[31:0];
        m_eexp = exp;
    endfunction

    function automatic void model_step();
        bit          act, com, bad;
        int          sz;
        logic [68:0] h;
        act   = !m_pass && !m_fail;
        sz    = mq.size();
        com   = act && wb_rf_we != 4'd0 && wb_rf_wnum != 5'd0;
        m_pop = act && sz > 0 && gold_valid;
        h     = (sz > 0) ? mq[0] : '0;
        bad   = m_pop && (h != {gold_pc, gold_wnum, gold_wdata});
        if (m_pop) begin
            mq.delete(0);
            if (!bad) m_cnt = m_cnt + 1;
        end
        if (com && (sz < DEPTH || m_pop)) mq.push_back({wb_pc, wb_rf_wnum, wb_rf_wdata});
        if (bad) capture(h, gold_wdata);
        else if (com && sz == DEPTH && !m_pop) begin
            m_fail = 1;
            m_ovf  = 1;
        end
        else if (act && gold_end && sz > 0 && !gold_valid) capture(h, 32'd0);
        else if (act && !m_drain && wb_pc == END_PC) m_drain = 1;
        else if (act && m_drain && sz == 0 && !com) m_pass = 1;
    endfunction

    task automatic compare_all(input string p);
        check({p, "_pass"}, 32'(pass), 32'(m_pass));
        check({p, "_fail"}, 32'(fail), 32'(m_fail));
        check({p, "_done"}, 32'(done), 32'(m_pass | m_fail));
        check({p, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check({p, "_checked_cnt"}, checked_cnt, m_cnt);
        check({p, "_err_pc"}, err_pc, m_epc);
        check({p, "_err_wnum"}, 32'(err_wnum), 32'(m_ewn));
        check({p, "_err_exp"}, err_exp_wdata, m_eexp);
        check({p, "_err_got"}, err_got_wdata, m_egot);
    endtask

    task automatic drive();
        wb_t s;
        bit  st;
        s = '{pc: IDLE_PC, we: 4'd0, wnum: 5'd0, wdata: 32'd0};
        if (stim.size() > 0) s = stim.pop_front();
        st = (stall_q.size() > 0) ? stall_q.pop_front() : ($urandom_range(99) < stall_pct);
        wb_pc = s.pc; wb_rf_we = s.we; wb_rf_wnum = s.wnum; wb_rf_wdata = s.wdata;
        gold_valid = gq.size() > 0 && !st;
        if (gold_valid) {gold_pc, gold_wnum, gold_wdata} = gq[0];
        else {gold_pc, gold_wnum, gold_wdata} = {$urandom, 5'($urandom), $urandom};
        gold_end = end_en && gq.size() == 0;
    endtask

    task automatic cycle(input string p);
        bit took;
        drive();
        #1;
        model_step();
        check({p, "_gold_ready"}, 32'(gold_ready), 32'(m_pop));
        took = gold_ready;
        if (took) ready_pulses++;
        @(posedge clk);
        #1;
        if (took && gq.size() > 0) gq.delete(0);
        compare_all(p);
        @(negedge clk);
    endtask

    task automatic run(input string p, input int n);
        repeat (n) cycle(p);
    endtask

    task automatic do_reset();
        stim.delete(); gq.delete(); stall_q.delete();
        stall_pct = 0; end_en = 0; ready_pulses = 0;
        reset = 1; wb_pc = IDLE_PC; wb_rf_we = 0; wb_rf_wnum = 0; wb_rf_wdata = 0;
        gold_valid = 0; gold_end = 0;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        gold_valid = 1;
        #1;
        check("rst_gold_ready", 32'(gold_ready), 32'd0);
        gold_valid = 0;
        compare_all("rst");
        @(negedge clk);
    endtask

    task automatic add_wb(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn, input logic [31:0] d);
        wb_t s;
        s.pc = pc; s.we = we; s.wnum = wn; s.wdata = d;
        stim.push_back(s);
    endtask

    task automatic add_pair(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] d, input logic [31:0] gd);
        add_wb(pc, 4'hf, wn, d);
        gq.push_back({pc, wn, gd});
    endtask

    task automatic lockstep(input string p);
        add_pair(32'h1c000000, 5'd1, 32'd1, 32'd1);
        add_pair(32'h1c000004, 5'd2, 32'd2, 32'd2);
        add_pair(32'h1c000008, 5'd3, 32'd3, 32'd3);
        add_wb(END_PC, 4'd0, 5'd0, 32'd0);
        run(p, 4);
        check({p, "_pass_early"}, 32'(pass), 32'd0);
        run(p, 1);
        check({p, "_pass"}, 32'(pass), 32'd1);
        check({p, "_cnt"}, checked_cnt, 32'd3);
        check({p, "_ready_pulses"}, 32'(ready_pulses), 32'd3);
    endtask

    initial begin
        do_reset();
        lockstep("lock");

        do_reset();
        add_pair(32'h1c000000, 5'd1, 32'd1, 32'd1);
        add_pair(32'h1c000004, 5'd2, 32'h6, 32'h5);
        add_pair(32'h1c000008, 5'd3, 32'h3, 32'h4);
        add_wb(END_PC, 4'd0, 5'd0, 32'd0);
        run("mism", 8);
        check("mism_fail", 32'(fail), 32'd1);
        check("mism_err_pc", err_pc, 32'h1c000004);
        check("mism_err_wnum", 32'(err_wnum), 32'd2);
        check("mism_err_exp", err_exp_wdata, 32'h5);
        check("mism_err_got", err_got_wdata, 32'h6);
        check("mism_cnt", checked_cnt, 32'd1);

        do_reset();
        stall_q = '{1, 1, 1, 1};
        for (int i = 0; i < 4; i++) add_pair(32'h1c000000 + 32'(4 * i), 5'(i + 1), 32'(10 + i), 32'(10 + i));
        add_wb(END_PC, 4'd0, 5'd0, 32'd0);
        run("stall", 12);
        check("stall_overflow", 32'(overflow), 32'd0);
        check("stall_cnt", checked_cnt, 32'd4);
        check("stall_pass", 32'(pass), 32'd1);

        do_reset();
        stall_q = '{1, 1, 1, 1, 1};
        for (int i = 0; i < 5; i++) add_pair(32'h1c000000 + 32'(4 * i), 5'(i + 1), 32'(20 + i), 32'(20 + i));
        run("ovf", 4);
        check("ovf_early", 32'(overflow), 32'd0);
        run("ovf", 1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_fail", 32'(fail), 32'd1);

        do_reset();
        stall_q = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) add_pair(32'h1c000000 + 32'(4 * i), 5'(i + 1), 32'(30 + i), 32'(30 + i));
        add_wb(END_PC, 4'd0, 5'd0, 32'd0);
        run("full_pp", 14);
        check("full_pp_overflow", 32'(overflow), 32'd0);
        check("full_pp_cnt", checked_cnt, 32'd5);
        check("full_pp_pass", 32'(pass), 32'd1);

        do_reset();
        add_wb(32'h1c000000, 4'hf, 5'd0, 32'd77);
        add_pair(32'h1c000004, 5'd1, 32'd7, 32'd7);
        add_wb(END_PC, 4'd0, 5'd0, 32'd0);
        run("r0", 6);
        check("r0_cnt", checked_cnt, 32'd1);
        check("r0_pass", 32'(pass), 32'd1);

        do_reset();
        end_en = 1;
        add_wb(32'h1c000010, 4'h1, 5'd5, 32'd9);
        run("extra", 3);
        check("extra_fail", 32'(fail), 32'd1);
        check("extra_err_exp", err_exp_wdata, 32'd0);
        check("extra_err_got", err_got_wdata, 32'd9);
        check("extra_err_pc", err_pc, 32'h1c000010);

        do_reset();
        stall_pct = 100;
        for (int i = 0; i < 3; i++) add_pair(32'h1c000000 + 32'(4 * i), 5'(i + 1), 32'(i), 32'(i));
        add_wb(END_PC, 4'd0, 5'd0, 32'd0);
        run("drain", 5);
        check("drain_done", 32'(done), 32'd0);
        do_reset();
        check("drain_rst_cnt", checked_cnt, 32'd0);
        lockstep("relock");

        for (int k = 0; k < 40; k++) begin
            int n;
            do_reset();
            stall_pct = $urandom_range(0, 60);
            end_en = 1'($urandom_range(0, 1));
            n = $urandom_range(3, 12);
            for (int i = 0; i <= n; i++) begin
                logic [31:0] pc;
                logic [4:0]  wn;
                logic [31:0] d;
                logic [3:0]  we;
                logic [68:0] g;
                pc = (i == n) ? END_PC : 32'h1c000000 + 32'(4 * i);
                wn = 5'($urandom_range(0, 31));
                d  = $urandom;
                we = ($urandom_range(99) < 70) ? 4'($urandom_range(1, 15)) : 4'd0;
                add_wb(pc, we, wn, d);
                if (we != 0 && wn != 0) begin
                    g = {pc, wn, d};
                    if ($urandom_range(99) < 8) g = g ^ (69'(1) << $urandom_range(0, 68));
                    gq.push_back(g);
                end
            end
            if ($urandom_range(99) < 10 && gq.size() > 0) gq.delete(gq.size() - 1);
            run("rand", n + 25);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
